// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through cache controller.
// Owns tag/valid state, drives the data SRAM and memory handshake.
module dm_cache_ctrl #(
  parameter  int ADDR_W   = 15,
  parameter  int INDEX_W  = 10,
  parameter  int OFFSET_W = 2,
  parameter  int WORD_W   = 32,
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  localparam int BLK_W    = WORD_W << OFFSET_W,
  localparam int LINES    = 1 << INDEX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_read,
  input  logic              cache_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cache_ready,
  output logic [WORD_W-1:0] cache_data,
  output logic [13:0]       hit_count,
  output logic [13:0]       miss_count,
  output logic [INDEX_W-1:0] da_index,
  output logic              da_we,
  output logic [BLK_W-1:0]  da_wdata,
  input  logic [BLK_W-1:0]  da_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_RD,
    S_FILL,
    S_MEM_WR,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic                r_wr;
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag [LINES];
  logic [BLK_W-1:0]    r_blk;
  logic [WORD_W-1:0]   r_data;
  logic [13:0]         r_hits;
  logic [13:0]         r_misses;

  logic                w_req;
  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [OFFSET_W-1:0] w_off;
  logic                w_hit;
  logic [WORD_W-1:0]   w_rword;
  logic [WORD_W-1:0]   w_bword;
  logic [BLK_W-1:0]    w_merge;

  assign w_req   = cache_read | cache_write;
  assign w_idx   = r_addr[OFFSET_W +: INDEX_W];
  assign w_tag   = r_addr[ADDR_W-1 -: TAG_W];
  assign w_off   = r_addr[OFFSET_W-1:0];
  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_rword = da_rdata[int'(w_off)*WORD_W +: WORD_W];
  assign w_bword = r_blk[int'(w_off)*WORD_W +: WORD_W];

  always_comb begin
    w_merge = da_rdata;
    w_merge[int'(w_off)*WORD_W +: WORD_W] = r_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_req) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (r_wr)       w_next = S_MEM_WR;
        else if (w_hit) w_next = S_RESP;
        else            w_next = S_MEM_RD;
      end
      S_MEM_RD: if (mem_ready) w_next = S_FILL;
      S_FILL:   w_next = S_RESP;
      S_MEM_WR: if (mem_ready) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cache_ready = 1'b0;
    da_index    = '0;
    da_we       = 1'b0;
    da_wdata    = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (r_state)
      // SRAM read is synchronous, so present the index a cycle early
      S_IDLE: if (rst && w_req)
        da_index = address[OFFSET_W +: INDEX_W];
      S_LOOKUP: begin
        da_index = w_idx;
        if (r_wr && w_hit) begin
          da_we    = 1'b1;
          da_wdata = w_merge;
        end
      end
      S_MEM_RD: begin
        da_index = w_idx;
        mem_read = 1'b1;
        mem_addr = {w_tag, w_idx, {OFFSET_W{1'b0}}};
      end
      S_FILL: begin
        da_index = w_idx;
        da_we    = 1'b1;
        da_wdata = r_blk;
      end
      S_MEM_WR: begin
        da_index  = w_idx;
        mem_write = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
      end
      S_RESP: begin
        da_index    = w_idx;
        cache_ready = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wr     <= 1'b0;
      r_valid  <= '0;
      r_blk    <= '0;
      r_data   <= '0;
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_req) begin
          r_addr  <= address;
          r_wdata <= cpu_wdata;
          r_wr    <= cache_write;
        end
        S_LOOKUP: if (!r_wr) begin
          if (w_hit) begin
            r_data <= w_rword;
            if (r_hits != '1) r_hits <= r_hits + 1'b1;
          end else if (r_misses != '1) begin
            r_misses <= r_misses + 1'b1;
          end
        end
        S_MEM_RD: if (mem_ready) r_blk <= mem_rdata;
        S_FILL: begin
          r_valid[w_idx] <= 1'b1;
          r_data         <= w_bword;
        end
        default: ;
      endcase
    end
  end

  // Tags are qualified by r_valid, so they need no reset
  always_ff @(posedge clk) begin
    if (r_state == S_FILL) r_tag[w_idx] <= w_tag;
  end

  assign cache_data = r_data;
  assign hit_count  = r_hits;
  assign miss_count = r_misses;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: vector table plus reset,
// dropped-request and counter-saturation sequences.
module tb_dm_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cache_read, cache_write;
  logic [14:0]  address;
  logic [31:0]  cpu_wdata;
  logic         cache_ready;
  logic [31:0]  cache_data;
  logic [13:0]  hit_count, miss_count;
  logic [9:0]   da_index;
  logic         da_we;
  logic [127:0] da_wdata;
  logic [127:0] da_rdata;
  logic         mem_read, mem_write;
  logic [14:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  dm_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cache_read(cache_read), .cache_write(cache_write),
    .address(address), .cpu_wdata(cpu_wdata),
    .cache_ready(cache_ready), .cache_data(cache_data),
    .hit_count(hit_count), .miss_count(miss_count),
    .da_index(da_index), .da_we(da_we),
    .da_wdata(da_wdata), .da_rdata(da_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // data SRAM model: 1-cycle synchronous read
  logic [127:0] sram [1024];
  always @(posedge clk) begin
    if (da_we) sram[da_index] <= da_wdata;
    da_rdata <= sram[da_index];
  end

  logic [31:0] mem [32768];
  int resp_lat = 2;
  int late_req = 0;
  int late_done = 0;
  int rcnt = 0;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
  end

  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (late_req != late_done) begin
      late_done++;
      mem_ready = 1'b1;
      mem_rdata = '1;
    end else if (mem_read || mem_write) begin
      rcnt++;
      if (rcnt >= resp_lat) begin
        rcnt = 0;
        mem_ready = 1'b1;
        if (mem_read) begin
          for (int k = 0; k < 4; k++)
            mem_rdata[k*32 +: 32] = mem[{mem_addr[14:2], 2'(k)}];
        end else begin
          mem[mem_addr] = mem_wdata;
        end
      end
    end else begin
      rcnt = 0;
    end
  end

  int we_total = 0;
  int overlap = 0;
  logic [127:0] last_wd = '0;
  always @(negedge clk) begin
    if (da_we) begin
      we_total++;
      last_wd = da_wdata;
    end
    if (mem_read && mem_write) overlap++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic txn(input bit wr, input logic [14:0] a,
                     input logic [31:0] d, input int lat,
                     output int cyc, output logic [31:0] data,
                     output bit saw_rd, output bit saw_wr,
                     output int wes);
    int we0;
    resp_lat = lat;
    we0 = we_total;
    @(negedge clk);
    cache_read  = !wr;
    cache_write = wr;
    address     = a;
    cpu_wdata   = d;
    cyc = 0;
    saw_rd = 0;
    saw_wr = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_read)  saw_rd = 1;
      if (mem_write) saw_wr = 1;
    end while (!cache_ready && cyc < 200);
    data = cache_data;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    wes = we_total - we0;
  endtask

  typedef struct {
    bit          wr;
    logic [14:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          cyc;
    logic [31:0] data;
    bit          rd_exp;
    bit          wr_exp;
    int          we;
    int          hits;
    int          misses;
    bit          chk_wd;
    logic [127:0] wd;
  } vec_t;

  function automatic vec_t mk(bit wr, int a, logic [31:0] wd,
                              int lat, int cyc, logic [31:0] data,
                              bit rd_e, bit wr_e, int we,
                              int h, int m, bit cw,
                              logic [127:0] blk);
    vec_t v;
    v.wr = wr; v.addr = 15'(a); v.wdata = wd; v.lat = lat;
    v.cyc = cyc; v.data = data; v.rd_exp = rd_e;
    v.wr_exp = wr_e; v.we = we; v.hits = h; v.misses = m;
    v.chk_wd = cw; v.wd = blk;
    return v;
  endfunction

  localparam logic [127:0] BLK1024 =
    {32'hD0000403, 32'hD0000402, 32'hD0000401, 32'hD0000400};
  localparam logic [127:0] BLKWR =
    {32'hD0000403, 32'hD0000402, 32'h0000CAFE, 32'hD0000400};

  vec_t tbl [11];

  initial begin
    int cyc, wes, w, bad;
    logic [31:0] data;
    bit srd, swr, seen;

    for (int i = 0; i < 32768; i++) mem[i] = 32'hD000_0000 + i;
    tbl[0]  = mk(0, 1024, 0, 4, 7, 32'hD0000400, 1, 0, 1, 0, 1, 1, BLK1024);
    tbl[1]  = mk(0, 1025, 0, 4, 2, 32'hD0000401, 0, 0, 0, 1, 1, 0, 0);
    tbl[2]  = mk(0, 1026, 0, 4, 2, 32'hD0000402, 0, 0, 0, 2, 1, 0, 0);
    tbl[3]  = mk(0, 1027, 0, 4, 2, 32'hD0000403, 0, 0, 0, 3, 1, 0, 0);
    tbl[4]  = mk(0, 5120, 0, 2, 5, 32'hD0001400, 1, 0, 1, 3, 2, 0, 0);
    tbl[5]  = mk(0, 1024, 0, 1, 4, 32'hD0000400, 1, 0, 1, 3, 3, 0, 0);
    tbl[6]  = mk(1, 1025, 32'h0000CAFE, 3, 5, 0, 0, 1, 1, 3, 3, 1, BLKWR);
    tbl[7]  = mk(0, 1025, 0, 2, 2, 32'h0000CAFE, 0, 0, 0, 4, 3, 0, 0);
    tbl[8]  = mk(1, 9000, 32'h12345678, 2, 4, 0, 0, 1, 0, 4, 3, 0, 0);
    tbl[9]  = mk(0, 9000, 0, 3, 6, 32'h12345678, 1, 0, 1, 4, 4, 0, 0);
    tbl[10] = mk(0, 5120, 0, 2, 5, 32'hD0001400, 1, 0, 1, 4, 5, 0, 0);

    rst = 1'b0;
    cache_read = 1'b0;
    cache_write = 1'b0;
    address = '0;
    cpu_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", cache_ready, 0);
    chk("reset_data", cache_data, 0);
    chk("reset_counts", {hit_count, miss_count}, 0);
    chk("reset_mem", {mem_read, mem_write, mem_addr}, 0);
    chk("reset_sram", {da_we, da_index, da_wdata}, 0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].lat,
          cyc, data, srd, swr, wes);
      chk($sformatf("v%0d_latency", i), cyc, tbl[i].cyc);
      if (!tbl[i].wr)
        chk($sformatf("v%0d_data", i), data, tbl[i].data);
      chk($sformatf("v%0d_mem_read", i), srd, tbl[i].rd_exp);
      chk($sformatf("v%0d_mem_write", i), swr, tbl[i].wr_exp);
      chk($sformatf("v%0d_da_we", i), wes, tbl[i].we);
      chk($sformatf("v%0d_hits", i), hit_count, tbl[i].hits);
      chk($sformatf("v%0d_misses", i), miss_count, tbl[i].misses);
      if (tbl[i].chk_wd)
        chk($sformatf("v%0d_da_wdata", i), last_wd, tbl[i].wd);
    end

    // reset while waiting in MEM_RD
    resp_lat = 1000;
    @(negedge clk);
    cache_read = 1'b1;
    address = 15'd1024;
    w = 0;
    while (!mem_read && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mem_rd_seen", mem_read, 1);
    chk("rst_mem_rd_addr", mem_addr, 15'd1024);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_mem", {mem_read, mem_write, mem_addr, mem_wdata}, 0);
    chk("rst_async_sram", {da_we, da_index, da_wdata}, 0);
    chk("rst_async_cpu", {cache_ready, cache_data}, 0);
    chk("rst_async_counts", {hit_count, miss_count}, 0);
    cache_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    late_req++;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (cache_ready || mem_read || mem_write || da_we) bad++;
    end
    chk("late_ready_ignored", bad, 0);
    txn(0, 15'd1024, 0, 2, cyc, data, srd, swr, wes);
    chk("post_rst_latency", cyc, 5);
    chk("post_rst_data", data, 32'hD0000400);
    chk("post_rst_miss", {srd, hit_count, miss_count}, {1'b1, 14'd0, 14'd1});

    // request dropped while the block fetch is in flight
    resp_lat = 3;
    @(negedge clk);
    cache_read = 1'b1;
    address = 15'd2048;
    w = 0;
    while (!mem_read && w < 20) begin
      @(negedge clk);
      w++;
    end
    cache_read = 1'b0;
    seen = 0;
    w = 0;
    while (!seen && w < 50) begin
      @(negedge clk);
      w++;
      if (cache_ready) seen = 1;
    end
    chk("drop_ready", seen, 1);
    chk("drop_data", cache_data, 32'hD0000800);
    chk("drop_miss", miss_count, 2);

    // saturation of the hit counter
    for (int i = 0; i < 16383; i++)
      txn(0, 15'd1024, 0, 2, cyc, data, srd, swr, wes);
    chk("sat_hits_max", hit_count, 14'd16383);
    for (int i = 0; i < 17; i++)
      txn(0, 15'd1024, 0, 2, cyc, data, srd, swr, wes);
    chk("sat_hits_hold", hit_count, 14'd16383);
    chk("sat_misses", miss_count, 2);
    chk("sat_last_data", data, 32'hD0000400);
    chk("rd_wr_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Direct-mapped, read-allocate, write-through/no-write-allocate cache controller that sits between the CPU traffic driver and main memory. It owns the tag/valid arrays, sequences an external single-port data SRAM and the memory read/write handshake, and reports hit and miss counts to the CPU for hit-rate computation. It serves one CPU request at a time.

Parameters:
ADDR_W, 15, CPU word address width
INDEX_W, 10, line index bits (1024 lines)
OFFSET_W, 2, word-in-block bits (4 words per block)
WORD_W, 32, data word width; block = WORD_W<<OFFSET_W = 128 bits
TAG_W, ADDR_W-INDEX_W-OFFSET_W (3), derived; not overridden

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cache_read  in  1  CPU read request, level, held until cache_ready
cache_write  in  1  CPU write request, level, held until cache_ready
address  in  ADDR_W  CPU word address
cpu_wdata  in  WORD_W  CPU write data
cache_ready  out  1  one-cycle completion pulse
cache_data  out  WORD_W  read data, valid while cache_ready=1
hit_count  out  14  read hits, saturating
miss_count  out  14  read misses, saturating
da_index  out  INDEX_W  data SRAM index
da_we  out  1  data SRAM write enable
da_wdata  out  128  data SRAM write block
da_rdata  in  128  data SRAM read block, 1-cycle synchronous read
mem_read  out  1  block read request, level
mem_write  out  1  word write request, level
mem_addr  out  ADDR_W  memory word address (low OFFSET_W bits 0 for block reads)
mem_wdata  out  WORD_W  memory write word
mem_rdata  in  128  block from memory, valid when mem_ready=1
mem_ready  in  1  one-cycle memory completion pulse

Behaviour:
- Address split: offset=[1:0], index=[11:2], tag=[14:12].
- Reset (rst=0, any state): FSM->IDLE; all valid bits cleared; all outputs 0; hit_count=miss_count=0. An in-flight memory transaction is abandoned; a late mem_ready is ignored in IDLE.
- States: IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, RESP.
- IDLE: when cache_write or cache_read is high, latch address/cpu_wdata/op (write wins if both), drive da_index=index -> LOOKUP. Otherwise stay.
- LOOKUP: hit = valid[index] && tag_arr[index]==latched tag.
  - Read hit: hit_count+1 (sat 16383), cache_data=word offset of da_rdata -> RESP.
  - Read miss: miss_count+1 (sat 16383) -> MEM_RD.
  - Write hit: da_we=1, da_wdata=da_rdata with word offset replaced by wdata -> MEM_WR.
  - Write miss: no array change -> MEM_WR. Writes never change counters.
- MEM_RD: mem_read=1, mem_addr={tag,index,2'b00} held stable until mem_ready; on mem_ready capture mem_rdata -> FILL.
- FILL: da_we=1, da_wdata=captured block; tag_arr[index]=tag, valid[index]=1; cache_data=captured word offset -> RESP.
- MEM_WR: mem_write=1, mem_addr=full address, mem_wdata=wdata until mem_ready -> RESP.
- RESP: cache_ready=1 for exactly this cycle; cache_data held; -> IDLE. Requests are not sampled in RESP (CPU updates address on this edge).
- Latency, request seen in IDLE at edge N: read hit cache_ready high in cycle N+2; read miss N+3+W, where W = cycles spent in MEM_RD up to and including the mem_ready cycle; write N+2+W.
- mem_read and mem_write never high simultaneously; da_we at most one cycle per request.
- Counters saturate at 16383 and never wrap.
- Request dropped by CPU mid-transaction: transaction still completes and cache_ready still pulses.

Test Plan:
- Reset, read 1024 (index 256, tag 0): mem_read with mem_addr=1024; mem_ready after 4 cycles with block {D3,D2,D1,D0} -> da_we one cycle; cache_ready pulse with cache_data=D0; miss_count=1, hit_count=0.
- Reads 1025, 1026, 1027 after the first test -> no mem_read; cache_ready 2 cycles after each sample; data D1, D2, D3; hit_count=3.
- Conflict: read 5120 (index 256, tag 1) -> miss; then read 1024 -> miss again; miss_count=3.
- Write 1025=0xCAFE on a resident line -> da_we with word1 replaced; mem_write, mem_addr=1025; then read 1025 -> hit, cache_data=0xCAFE. Write to non-resident 9000 -> mem_write only, da_we stays 0.
- Assert rst during MEM_RD -> all outputs 0 immediately; late mem_ready ignored; a read of 1024 afterwards misses.
- 16400 consecutive hits -> hit_count holds 16383.
